dmem_responder: RTL and testbench

//  Data-memory responder for the RV32IM pipeline's MEM stage: accepts one load/store

---
 rtl/dmem_responder_pkg.sv | 39 +++
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder_lane_align.sv | 56 +++++
 rtl/dmem_responder.sv | 170 +++++++++++++++++
 tb/tb_dmem_responder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states,
// latency counter width and the alignment/funct3 legality check.
package dmem_responder_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Covers illegal funct3 and misalignment; the address range is checked by the
    // caller because it depends on the array depth.
    function automatic logic access_error(input logic       write,
                                          input logic [2:0] funct3,
                                          input logic [1:0] off);
        logic bad_f3;
        logic misaligned;
        if (write) begin
            bad_f3 = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        end else begin
            bad_f3 = (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
        end
        case (funct3[1:0])
            2'd1:    misaligned = off[0];
            2'd2:    misaligned = (off != 2'd0);
            default: misaligned = 1'b0;
        endcase
        return bad_f3 || misaligned;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_responder_lane_align.sv
// Combinational byte-lane steering: store byte enables and data replication,
// load byte/half extraction with sign or zero extension.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Replicating the store data into every lane lets the byte enables alone pick the target bytes.
    always_comb begin
        byte_en   = 4'b0000;
        wdata_rep = wdata;
        case (funct3)
            F3_B: begin
                byte_en   = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
            end
            F3_H: begin
                byte_en   = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            F3_W: begin
                byte_en   = 4'b1111;
                wdata_rep = wdata;
            end
            default: begin
                byte_en   = 4'b0000;
                wdata_rep = wdata;
            end
        endcase
    end

    always_comb begin
        byte_sel  = rword[8*off +: 8];
        half_sel  = off[1] ? rword[31:16] : rword[15:0];
        rdata_ext = 32'd0;
        case (funct3)
            F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
            F3_W:    rdata_ext = rword;
            F3_BU:   rdata_ext = {24'd0, byte_sel};
            F3_HU:   rdata_ext = {16'd0, half_sel};
            default: rdata_ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one request at a time, fixed LATENCY-cycle
// access, byte-enabled word array, extended load data and error reporting.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
)
(
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int                IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0]       ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(LATENCY - 1);

    dmem_state_t      state;
    dmem_state_t      next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             go_resp;

    logic             hold_write;
    logic [2:0]       hold_funct3;
    logic [31:0]      hold_addr;
    logic [31:0]      hold_wdata;

    logic             cur_write;
    logic [2:0]       cur_funct3;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic             cur_err;
    logic [IDX_W-1:0] cur_idx;

    logic [3:0]       byte_en;
    logic [31:0]      wdata_rep;
    logic [31:0]      rdata_ext;
    logic [31:0]      rword;
    logic             mem_we;

    logic [31:0]      resp_rdata_q;
    logic             resp_err_q;

    logic [31:0]      mem [DEPTH_WORDS];

    // With LATENCY=1 the access happens on the accept edge itself, before the holding
    // registers are loaded, so the live bus request is used while idle.
    always_comb begin
        if (state == IDLE) begin
            cur_write  = bus.req_write;
            cur_funct3 = bus.req_funct3;
            cur_addr   = bus.req_addr;
            cur_wdata  = bus.req_wdata;
        end else begin
            cur_write  = hold_write;
            cur_funct3 = hold_funct3;
            cur_addr   = hold_addr;
            cur_wdata  = hold_wdata;
        end
        cur_err = access_error(cur_write, cur_funct3, cur_addr[1:0])
                  || ({1'b0, cur_addr} >= ADDR_LIMIT);
        cur_idx = cur_addr[IDX_W+1:2];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // The counter is loaded with 1 on accept so it equals the cycles elapsed since the accept edge.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        go_resp    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 1) begin
                        next_state = RESP;
                        go_resp    = 1'b1;
                    end else begin
                        next_state = BUSY;
                        next_cnt   = CNT_W'(1);
                    end
                end
            end
            BUSY: begin
                if (cnt == LAST_CNT) begin
                    next_state = RESP;
                    next_cnt   = '0;
                    go_resp    = 1'b1;
                end else begin
                    next_cnt = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_write  <= 1'b0;
            hold_funct3 <= 3'd0;
            hold_addr   <= 32'd0;
            hold_wdata  <= 32'd0;
        end else if (state == IDLE && bus.req_valid) begin
            hold_write  <= bus.req_write;
            hold_funct3 <= bus.req_funct3;
            hold_addr   <= bus.req_addr;
            hold_wdata  <= bus.req_wdata;
        end
    end

    dmem_lane_align u_lane_align (
        .funct3    (cur_funct3),
        .off       (cur_addr[1:0]),
        .wdata     (cur_wdata),
        .rword     (rword),
        .byte_en   (byte_en),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    assign rword  = mem[cur_idx];
    assign mem_we = reset && go_resp && cur_write && !cur_err;

    // The array has no reset; contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[cur_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else if (go_resp) begin
            resp_err_q   <= cur_err;
            resp_rdata_q <= (cur_err || cur_write) ? 32'd0 : rdata_ext;
        end else if (state == RESP) begin
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder with LATENCY=2 for data/error/reset cases and one
// with LATENCY=1 for back-to-back throughput.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    dmem_responder_if bus2();
    dmem_responder_if bus1();

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Full LATENCY=2 transaction: accept, one BUSY cycle, one RESP cycle, back to idle.
    task automatic txn2(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input logic exp_err);
        logic [5:0]  t;
        logic [31:0] rd;
        logic        er;
        logic        leftover;
        @(negedge clk);
        bus2.req_valid  = 1'b1;
        bus2.req_write  = wr;
        bus2.req_funct3 = f3;
        bus2.req_addr   = addr;
        bus2.req_wdata  = wd;
        @(posedge clk); #1;
        t[5:4] = {bus2.req_ready, bus2.resp_valid};
        bus2.req_valid = 1'b0;
        bus2.req_addr  = 32'hFFFF_FFFF;
        bus2.req_wdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        t[3:2] = {bus2.req_ready, bus2.resp_valid};
        rd = bus2.resp_rdata;
        er = bus2.resp_err;
        @(posedge clk); #1;
        t[1:0] = {bus2.req_ready, bus2.resp_valid};
        leftover = (bus2.resp_rdata != 32'd0) || bus2.resp_err;
        check({tag, " timing"}, 32'(t), 32'b000110);
        check({tag, " rdata"}, rd, exp_rdata);
        check({tag, " err"}, 32'(er), 32'(exp_err));
        check({tag, " cleared"}, 32'(leftover), 32'd0);
    endtask

    task automatic txn1(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rdata);
        logic [3:0]  t;
        logic [31:0] rd;
        @(negedge clk);
        bus1.req_valid  = 1'b1;
        bus1.req_write  = wr;
        bus1.req_funct3 = f3;
        bus1.req_addr   = addr;
        bus1.req_wdata  = wd;
        @(posedge clk); #1;
        t[3:2] = {bus1.req_ready, bus1.resp_valid};
        rd = bus1.resp_rdata;
        bus1.req_valid = 1'b0;
        @(posedge clk); #1;
        t[1:0] = {bus1.req_ready, bus1.resp_valid};
        check({tag, " timing"}, 32'(t), 32'b0110);
        check({tag, " rdata"}, rd, exp_rdata);
    endtask

    initial begin
        logic        seen;
        logic        will_accept;
        logic        prev_valid;
        int          cyc;
        int          acc_cnt;
        int          resp_cnt;
        int          acc_cycle[4];
        logic [31:0] b2b_addr[4];
        logic [31:0] b2b_data[4];

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_funct3 = 3'd0;
        bus2.req_addr  = 32'd0; bus2.req_wdata = 32'd0;
        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_funct3 = 3'd0;
        bus1.req_addr  = 32'd0; bus1.req_wdata = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        check("reset outputs lat2", {bus2.req_ready, bus2.resp_valid, bus2.resp_err, bus2.resp_rdata[28:0]},
              {3'b100, 29'd0});
        check("reset outputs lat1", {bus1.req_ready, bus1.resp_valid, bus1.resp_err, bus1.resp_rdata[28:0]},
              {3'b100, 29'd0});
        @(negedge clk);
        reset = 1'b1;
        $display("[TB] reset released");

        txn2("SW deadbeef", 1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0);
        txn2("LW deadbeef", 1'b0, F3_W, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);

        // Reset while BUSY must drop the store and suppress its response.
        @(negedge clk);
        bus2.req_valid  = 1'b1;
        bus2.req_write  = 1'b1;
        bus2.req_funct3 = F3_W;
        bus2.req_addr   = 32'h10;
        bus2.req_wdata  = 32'h1234_5678;
        @(posedge clk); #1;
        bus2.req_valid = 1'b0;
        check("abort accepted ready", 32'(bus2.req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("abort async ready", 32'(bus2.req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen = seen | bus2.resp_valid;
        end
        check("abort no resp", 32'(seen), 32'd0);
        check("abort ready idle", 32'(bus2.req_ready), 32'd1);
        txn2("LW after abort", 1'b0, F3_W, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);

        txn2("SW zero", 1'b1, F3_W, 32'h10, 32'h0000_0000, 32'd0, 1'b0);
        txn2("SB 80", 1'b1, F3_B, 32'h13, 32'h1234_5680, 32'd0, 1'b0);
        txn2("LW after SB", 1'b0, F3_W, 32'h10, 32'd0, 32'h8000_0000, 1'b0);
        txn2("LB 13", 1'b0, F3_B, 32'h13, 32'd0, 32'hFFFF_FF80, 1'b0);
        txn2("LBU 13", 1'b0, F3_BU, 32'h13, 32'd0, 32'h0000_0080, 1'b0);

        txn2("SW preset", 1'b1, F3_W, 32'h10, 32'h1122_3344, 32'd0, 1'b0);
        txn2("SH 8001", 1'b1, F3_H, 32'h12, 32'hFFFF_8001, 32'd0, 1'b0);
        txn2("LW after SH", 1'b0, F3_W, 32'h10, 32'd0, 32'h8001_3344, 1'b0);
        txn2("LH 12", 1'b0, F3_H, 32'h12, 32'd0, 32'hFFFF_8001, 1'b0);
        txn2("LHU 12", 1'b0, F3_HU, 32'h12, 32'd0, 32'h0000_8001, 1'b0);
        txn2("LH 10", 1'b0, F3_H, 32'h10, 32'd0, 32'h0000_3344, 1'b0);
        txn2("LB 11", 1'b0, F3_B, 32'h11, 32'd0, 32'h0000_0033, 1'b0);

        txn2("SW cafef00d", 1'b1, F3_W, 32'h20, 32'hCAFE_F00D, 32'd0, 1'b0);
        txn2("err LW 11", 1'b0, F3_W, 32'h11, 32'd0, 32'd0, 1'b1);
        txn2("err SH 21", 1'b1, F3_H, 32'h21, 32'h0000_BEEF, 32'd0, 1'b1);
        txn2("err SW 22", 1'b1, F3_W, 32'h22, 32'h0BAD_0BAD, 32'd0, 1'b1);
        txn2("err LW range", 1'b0, F3_W, 32'h1000, 32'd0, 32'd0, 1'b1);
        txn2("err load f3=3", 1'b0, 3'd3, 32'h10, 32'd0, 32'd0, 1'b1);
        txn2("err store f3=4", 1'b1, 3'd4, 32'h20, 32'h7777_7777, 32'd0, 1'b1);
        txn2("err store f3=3", 1'b1, 3'd3, 32'h20, 32'h6666_6666, 32'd0, 1'b1);
        txn2("LW 20 untouched", 1'b0, F3_W, 32'h20, 32'd0, 32'hCAFE_F00D, 1'b0);
        txn2("LW 10 untouched", 1'b0, F3_W, 32'h10, 32'd0, 32'h8001_3344, 1'b0);

        b2b_addr[0] = 32'h00; b2b_data[0] = 32'h0A0B_0C0D;
        b2b_addr[1] = 32'h04; b2b_data[1] = 32'h1111_2222;
        b2b_addr[2] = 32'h08; b2b_data[2] = 32'h8765_4321;
        b2b_addr[3] = 32'h0C; b2b_data[3] = 32'hFEDC_BA98;
        for (int i = 0; i < 4; i++) begin
            txn1("lat1 SW", 1'b1, F3_W, b2b_addr[i], b2b_data[i], 32'd0);
        end

        // req_valid stays high; a new request is presented right after each accept.
        @(negedge clk);
        bus1.req_valid  = 1'b1;
        bus1.req_write  = 1'b0;
        bus1.req_funct3 = F3_W;
        bus1.req_addr   = b2b_addr[0];
        cyc = 0;
        acc_cnt = 0;
        resp_cnt = 0;
        prev_valid = 1'b0;
        for (int i = 0; i < 4; i++) acc_cycle[i] = 0;
        while (resp_cnt < 4 && cyc < 20) begin
            will_accept = bus1.req_ready && bus1.req_valid;
            @(posedge clk); #1;
            cyc++;
            if (will_accept) begin
                acc_cycle[acc_cnt] = cyc;
                acc_cnt++;
                if (acc_cnt < 4) bus1.req_addr = b2b_addr[acc_cnt];
                else bus1.req_valid = 1'b0;
            end
            if (bus1.resp_valid) begin
                check("b2b merged pulse", 32'(prev_valid), 32'd0);
                check("b2b rdata", bus1.resp_rdata, b2b_data[resp_cnt]);
                check("b2b resp cycle", cyc, acc_cycle[resp_cnt]);
                resp_cnt++;
            end
            prev_valid = bus1.resp_valid;
            @(negedge clk);
        end
        check("b2b resp count", resp_cnt, 32'd4);
        check("b2b accept count", acc_cnt, 32'd4);
        for (int i = 1; i < 4; i++) begin
            check("b2b accept spacing", acc_cycle[i] - acc_cycle[i-1], 32'd2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
